// File: rtl/reset_conditioner_pkg.sv
// Shared types and helpers for the pushbutton reset conditioner.
package reset_conditioner_pkg;

    // Conditioner states. STRETCH, HELD and DB_RELEASE keep the system in reset.
    typedef enum logic [2:0] {
        RC_STRETCH,
        RC_RUN,
        RC_DB_PRESS,
        RC_HELD,
        RC_DB_RELEASE
    } rc_state_t;

    // Width of the shared debounce/stretch counter. It must be able to hold
    // the larger of the two terminal counts.
    function automatic int cnt_width(input int debounce_cycles, input int stretch_cycles);
        int longest;
        longest = (debounce_cycles > stretch_cycles) ? debounce_cycles : stretch_cycles;
        if (longest < 1) begin
            longest = 1;
        end
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic multi-flop synchroniser for a single asynchronous input bit.
// Reset loads every stage with RESET_VAL so the output starts at a known level.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stages;

    // Shift the raw input through the flop chain; the last stage is the synchronised value.
    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= {STAGES{RESET_VAL}};
        end else begin
            stages <= {stages[STAGES-2:0], d};
        end
    end

    assign q = stages[STAGES-1];

endmodule

// File: rtl/reset_conditioner.sv
// Pushbutton reset conditioner: synchronises and debounces the active-low
// board button, then produces a registered, stretched active-high system
// reset plus a one-cycle pulse for every accepted press.
module reset_conditioner
    import reset_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int STRETCH_CYCLES  = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic system_reset,
    output logic btn_event
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, STRETCH_CYCLES);

    // Terminal counts: the counter is cleared on the transition taken at
    // these values, so it never reaches its maximum and never wraps.
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             btn_sync;
    logic             btn_s;
    rc_state_t        state;
    rc_state_t        next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             system_reset_next;
    logic             btn_event_next;

    // The button idles high (released), so the synchroniser resets to 1 and
    // a press cannot be invented while the chain fills.
    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_btn_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_n),
        .q     (btn_sync)
    );

    // Flip to active-high so the rest of the logic reads 1 as pressed.
    assign btn_s = ~btn_sync;

    // State register with the registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RC_STRETCH;
            cnt          <= CNT_ZERO;
            system_reset <= 1'b1;
            btn_event    <= 1'b0;
        end else begin
            state        <= next_state;
            cnt          <= cnt_next;
            system_reset <= system_reset_next;
            btn_event    <= btn_event_next;
        end
    end

    // Next-state and shared counter: the counter runs only while stretching
    // or debouncing and is cleared whenever the state changes.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            RC_STRETCH: begin
                if (cnt == ST_LAST) begin
                    next_state = btn_s ? RC_HELD : RC_RUN;
                    cnt_next   = CNT_ZERO;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            RC_RUN: begin
                cnt_next = CNT_ZERO;
                if (btn_s) begin
                    next_state = RC_DB_PRESS;
                end
            end
            RC_DB_PRESS: begin
                if (!btn_s) begin
                    next_state = RC_RUN;
                    cnt_next   = CNT_ZERO;
                end else if (cnt == DB_LAST) begin
                    next_state = RC_HELD;
                    cnt_next   = CNT_ZERO;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            RC_HELD: begin
                cnt_next = CNT_ZERO;
                if (!btn_s) begin
                    next_state = RC_DB_RELEASE;
                end
            end
            RC_DB_RELEASE: begin
                if (btn_s) begin
                    next_state = RC_HELD;
                    cnt_next   = CNT_ZERO;
                end else if (cnt == DB_LAST) begin
                    next_state = RC_STRETCH;
                    cnt_next   = CNT_ZERO;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                next_state = RC_STRETCH;
                cnt_next   = CNT_ZERO;
            end
        endcase
    end

    // Output decode from the upcoming state so both outputs can be registered
    // without adding a cycle of latency.
    always_comb begin
        system_reset_next = (next_state == RC_STRETCH) ||
                            (next_state == RC_HELD)    ||
                            (next_state == RC_DB_RELEASE);
        btn_event_next    = (state == RC_DB_PRESS) && (next_state == RC_HELD);
    end

endmodule

// File: tb/tb_reset_conditioner.sv
// Testbench for reset_conditioner: directed scenarios plus randomised button
// activity, scored against a behavioural model of stable-run lengths.
module tb_reset_conditioner;

    localparam int SYNC    = 2;
    localparam int DB      = 4;
    localparam int STRETCH = 3;

    // Behavioural model phases: system running, held in reset by the button,
    // or stretching the reset after power-up / release.
    localparam int M_RUNNING    = 0;
    localparam int M_HOLDING    = 1;
    localparam int M_STRETCHING = 2;

    logic clk;
    logic reset;
    logic btn_n;
    logic system_reset;
    logic btn_event;

    int checks;
    int errors;

    // Expected {system_reset, btn_event} for each upcoming clock edge.
    logic [1:0] exp_q[$];

    // Model state.
    bit sync_hist[SYNC];
    int mode;
    int run_len;
    int elapsed;

    reset_conditioner #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB),
        .STRETCH_CYCLES  (STRETCH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_n        (btn_n),
        .system_reset (system_reset),
        .btn_event    (btn_event)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the model by one clock edge. A press is accepted after the
    // synchronised button has been seen pressed on DB+1 consecutive edges
    // while running; a release likewise after DB+1 consecutive released edges
    // while holding; the stretch lasts STRETCH edges and then follows the button.
    task automatic model_step(input bit rst, input bit pin, output logic [1:0] expv);
        bit pressed;
        bit ev;
        ev = 1'b0;
        if (rst) begin
            for (int i = 0; i < SYNC; i++) sync_hist[i] = 1'b1;
            mode    = M_STRETCHING;
            run_len = 0;
            elapsed = 0;
            expv    = 2'b10;
            return;
        end
        pressed = !sync_hist[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) sync_hist[i] = sync_hist[i-1];
        sync_hist[0] = pin;
        case (mode)
            M_STRETCHING: begin
                elapsed++;
                if (elapsed == STRETCH) begin
                    mode    = pressed ? M_HOLDING : M_RUNNING;
                    run_len = 0;
                end
            end
            M_RUNNING: begin
                run_len = pressed ? run_len + 1 : 0;
                if (run_len == DB + 1) begin
                    mode    = M_HOLDING;
                    run_len = 0;
                    ev      = 1'b1;
                end
            end
            default: begin
                run_len = pressed ? 0 : run_len + 1;
                if (run_len == DB + 1) begin
                    mode    = M_STRETCHING;
                    elapsed = 0;
                    run_len = 0;
                end
            end
        endcase
        expv = {mode != M_RUNNING, ev};
    endtask

    // Drive inputs on the falling edge for n cycles, queueing the expected
    // response of each following rising edge.
    task automatic apply_stimulus(input bit rst, input bit pin, input int n);
        logic [1:0] expv;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = rst;
            btn_n = pin;
            model_step(rst, pin, expv);
            exp_q.push_back(expv);
        end
    endtask

    task automatic check_output(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, actual, expected, $time);
        end
    endtask

    // Hold the button at pin and count edges until system_reset reaches target.
    task automatic measure_latency(input bit pin, input logic target, input int expected, input string name);
        int edges;
        bit seen;
        edges = 0;
        seen  = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            apply_stimulus(1'b0, pin, 1);
            @(posedge clk);
            #1;
            if (system_reset === target) begin
                seen  = 1'b1;
                edges = i;
            end
        end
        checks++;
        if (!seen || edges != expected) begin
            errors++;
            $display("[TB] FAIL %s latency actual=%0d expected=%0d (seen=%0b)", name, edges, expected, seen);
        end
    endtask

    // Monitor: one expected entry is consumed per rising edge after stimulus begins.
    initial begin
        logic [1:0] expv;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                expv = exp_q.pop_front();
                check_output("system_reset", system_reset, expv[1]);
                check_output("btn_event", btn_event, expv[0]);
            end
        end
    end

    // Stimulus: directed scenarios, then randomised presses, bounces and resets.
    initial begin
        int sel;
        bit lvl;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        btn_n  = 1'b1;

        // Power-up reset, then stretch into RUN.
        apply_stimulus(1'b1, 1'b1, 5);
        apply_stimulus(1'b0, 1'b1, 8);

        // Clean press: 2 sync + 4 debounce + 1 edges.
        measure_latency(1'b0, 1'b1, SYNC + DB + 1, "press");
        apply_stimulus(1'b0, 1'b0, 6);

        // Bounce on release, then clean release.
        apply_stimulus(1'b0, 1'b1, 2);
        apply_stimulus(1'b0, 1'b0, 1);
        measure_latency(1'b1, 1'b0, SYNC + DB + STRETCH + 1, "release");
        apply_stimulus(1'b0, 1'b1, 4);

        // Short glitch is rejected.
        apply_stimulus(1'b0, 1'b0, 3);
        apply_stimulus(1'b0, 1'b1, 10);

        // Button held through reset lands in HELD with no event.
        apply_stimulus(1'b1, 1'b0, 5);
        apply_stimulus(1'b0, 1'b0, 10);
        measure_latency(1'b1, 1'b0, SYNC + DB + STRETCH + 1, "held_release");
        apply_stimulus(1'b0, 1'b1, 4);

        // Reset mid debounce.
        apply_stimulus(1'b0, 1'b0, 5);
        apply_stimulus(1'b1, 1'b0, 1);
        apply_stimulus(1'b1, 1'b1, 2);
        apply_stimulus(1'b0, 1'b1, 8);

        // Randomised activity.
        for (int k = 0; k < 250; k++) begin
            sel = int'($urandom_range(0, 99));
            lvl = 1'($urandom_range(0, 1));
            if (sel < 5) begin
                apply_stimulus(1'b1, lvl, int'($urandom_range(1, 3)));
            end else if (sel < 55) begin
                apply_stimulus(1'b0, lvl, int'($urandom_range(1, 3)));
            end else begin
                apply_stimulus(1'b0, lvl, int'($urandom_range(4, 14)));
            end
        end

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
